// File: rtl/turbo_encoder_if.sv
// Turbo encoder stream bundle: 2-bit block input with bof/eof framing, 6-bit coded output,
// valid/ready on both sides; the encoder connects through the slave modport.
interface turbo_encoder_if;
  logic [5:0] param_sel;
  logic       i_valid;
  logic       i_bof;
  logic       i_eof;
  logic [1:0] i_data;
  logic       o_ready;
  logic       i_ready;
  logic       o_valid;
  logic       o_bof;
  logic       o_eof;
  logic [5:0] o_data;

  modport master (
    output param_sel, i_valid, i_bof, i_eof, i_data, i_ready,
    input  o_ready, o_valid, o_bof, o_eof, o_data
  );

  modport slave (
    input  param_sel, i_valid, i_bof, i_eof, i_data, i_ready,
    output o_ready, o_valid, o_bof, o_eof, o_data
  );
endinterface

// File: rtl/turbo_encoder.sv
// Rate-1/3 LTE-style turbo encoder: buffers a block at 2 bits/cycle, then emits K/2 words of
// {x,z,z'} x2; first word 2 cycles after eof, input blocked (o_ready=0) and state frozen while stalled.
module turbo_encoder #(
  parameter int MAX_K = 256
) (
  input logic            clk,
  input logic            rst,
  turbo_encoder_if.slave bus
);
  localparam int WW = $clog2(MAX_K / 2);
  localparam int CW = WW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, ENC} state_t;
  state_t state, state_nxt;

  logic [1:0]    mem [0:MAX_K/2-1];
  logic [2:0]    psel_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic          prime;
  logic [8:0]    pi_a;
  logic [8:0]    g_a;
  logic [2:0]    rsc1;
  logic [2:0]    rsc2;
  logic          o_valid_q;
  logic          o_bof_q;
  logic          o_eof_q;
  logic [5:0]    o_data_q;

  logic [8:0]    k_len, f1, f2, f2x2, g0;
  logic [CW-1:0] half_k;
  logic [8:0]    pi_b, g_b, pi_n, g_n;
  logic [CW-1:0] ia_w, ib_w;
  logic [1:0]    word_s, word_ia, word_ib;
  logic          u_a, u_b, ui_a, ui_b;
  logic [3:0]    r1a, r1b, r2a, r2b;
  logic [5:0]    enc_word;
  logic          wr_en, enter_enc, load_out, last_xfer;
  logic [WW-1:0] wr_addr;

  function automatic logic [8:0] mod_add(input logic [8:0] a, input logic [8:0] b,
                                         input logic [8:0] k);
    logic [8:0] sum;
    sum = a + b;
    return (sum >= k) ? sum - k : sum;
  endfunction

  // s = {s1, s2, s3}; returns {parity, next state}
  function automatic logic [3:0] rsc_step(input logic [2:0] s, input logic u);
    logic fb;
    fb = u ^ s[1] ^ s[0];
    return {fb ^ s[2] ^ s[0], fb, s[2], s[1]};
  endfunction

  always_comb begin
    k_len = 9'd112;
    f1    = 9'd41;
    f2    = 9'd84;
    case (psel_q)
      3'd1: begin k_len = 9'd40; f1 = 9'd3;  f2 = 9'd10; end
      3'd2: begin k_len = 9'd48; f1 = 9'd7;  f2 = 9'd12; end
      3'd3: begin k_len = 9'd56; f1 = 9'd19; f2 = 9'd42; end
      3'd4: begin k_len = 9'd64; f1 = 9'd7;  f2 = 9'd16; end
      default: ;
    endcase
  end

  assign half_k = CW'(k_len >> 1);
  assign f2x2   = mod_add(f2, f2, k_len);
  assign g0     = mod_add(f1, f2, k_len);

  // Two interleaver steps per cycle: a = pi(2j), b = pi(2j+1), n = pi(2j+2)
  assign pi_b = mod_add(pi_a, g_a, k_len);
  assign g_b  = mod_add(g_a, f2x2, k_len);
  assign pi_n = mod_add(pi_b, g_b, k_len);
  assign g_n  = mod_add(g_b, f2x2, k_len);

  // Words beyond the stored count read as zero, so short blocks are zero-filled
  always_comb begin
    ia_w    = CW'(pi_a >> 1);
    ib_w    = CW'(pi_b >> 1);
    word_s  = (rd_cnt < wr_cnt) ? mem[rd_cnt[WW-1:0]] : 2'b00;
    word_ia = (ia_w < wr_cnt) ? mem[ia_w[WW-1:0]] : 2'b00;
    word_ib = (ib_w < wr_cnt) ? mem[ib_w[WW-1:0]] : 2'b00;
    u_a     = word_s[1];
    u_b     = word_s[0];
    ui_a    = pi_a[0] ? word_ia[0] : word_ia[1];
    ui_b    = pi_b[0] ? word_ib[0] : word_ib[1];
  end

  assign r1a      = rsc_step(rsc1, u_a);
  assign r1b      = rsc_step(r1a[2:0], u_b);
  assign r2a      = rsc_step(rsc2, ui_a);
  assign r2b      = rsc_step(r2a[2:0], ui_b);
  assign enc_word = {u_a, r1a[3], r2a[3], u_b, r1b[3], r2b[3]};

  assign wr_en     = bus.i_valid && ((state == IDLE) ? bus.i_bof : (state == LOAD));
  assign wr_addr   = bus.i_bof ? '0 : wr_cnt[WW-1:0];
  assign enter_enc = (state != ENC) && (state_nxt == ENC);
  assign load_out  = (state == ENC) && !prime && (rd_cnt < half_k) &&
                     (!o_valid_q || bus.i_ready);
  assign last_xfer = o_valid_q && bus.i_ready && o_eof_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.o_ready = 1'b1;
    case (state)
      IDLE: begin
        if (bus.i_valid && bus.i_bof) state_nxt = bus.i_eof ? ENC : LOAD;
      end
      LOAD: begin
        if (bus.i_valid) begin
          if (bus.i_bof)
            state_nxt = bus.i_eof ? ENC : LOAD;
          else if (bus.i_eof || (wr_cnt + CW'(1) >= half_k))
            state_nxt = ENC;
        end
      end
      ENC: begin
        bus.o_ready = 1'b0;
        if (last_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q    <= 3'd0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      prime     <= 1'b0;
      pi_a      <= 9'd0;
      g_a       <= 9'd0;
      rsc1      <= 3'd0;
      rsc2      <= 3'd0;
      o_valid_q <= 1'b0;
      o_bof_q   <= 1'b0;
      o_eof_q   <= 1'b0;
      o_data_q  <= 6'd0;
    end else begin
      if (wr_en) begin
        if (bus.i_bof) begin
          wr_cnt <= CW'(1);
          psel_q <= (bus.param_sel < 6'd5) ? bus.param_sel[2:0] : 3'd0;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
      prime <= enter_enc;
      if (prime) begin
        pi_a   <= 9'd0;
        g_a    <= g0;
        rsc1   <= 3'd0;
        rsc2   <= 3'd0;
        rd_cnt <= '0;
      end else if (load_out) begin
        pi_a      <= pi_n;
        g_a       <= g_n;
        rsc1      <= r1b[2:0];
        rsc2      <= r2b[2:0];
        rd_cnt    <= rd_cnt + CW'(1);
        o_data_q  <= enc_word;
        o_bof_q   <= (rd_cnt == '0);
        o_eof_q   <= (rd_cnt == half_k - CW'(1));
        o_valid_q <= 1'b1;
      end else if (o_valid_q && bus.i_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_bof   = o_bof_q;
  assign bus.o_eof   = o_eof_q;
  assign bus.o_data  = o_data_q;
endmodule

// File: tb/tb_turbo_encoder.sv
// Directed bench for turbo_encoder: hand-computed vectors plus a direct-form LTE reference.
`timescale 1ns/1ps
module tb_turbo_encoder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  turbo_encoder_if bus ();
  turbo_encoder #(.MAX_K(256)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic       blk   [0:255];
  logic [5:0] exp_w [0:127];
  logic [5:0] got_d [0:127];
  logic       got_b [0:127];
  logic       got_e [0:127];
  int         n_got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder using the closed-form interleaver (f1*i + f2*i^2) mod K
  task automatic build_model(input int k, input int f1, input int f2);
    bit s1, s2, s3, t1, t2, t3, fb, u, ui, zp, zi;
    s1 = 0; s2 = 0; s3 = 0; t1 = 0; t2 = 0; t3 = 0;
    for (int i = 0; i < k; i++) begin
      u  = blk[i];
      ui = blk[(f1 * i + f2 * i * i) % k];
      fb = u ^ s2 ^ s3;  zp = fb ^ s1 ^ s3; s3 = s2; s2 = s1; s1 = fb;
      fb = ui ^ t2 ^ t3; zi = fb ^ t1 ^ t3; t3 = t2; t2 = t1; t1 = fb;
      if (i % 2 == 0) exp_w[i/2][5:3] = {u, zp, zi};
      else            exp_w[i/2][2:0] = {u, zp, zi};
    end
  endtask

  task automatic fill(input bit rnd, input int keep_bits);
    for (int i = 0; i < 256; i++)
      blk[i] = (rnd && i < keep_bits) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic send_block(input int psel, input int nw);
    for (int j = 0; j < nw; j++) begin
      @(negedge clk);
      bus.param_sel = 6'(psel);
      bus.i_valid   = 1'b1;
      bus.i_bof     = (j == 0);
      bus.i_eof     = (j == nw - 1);
      bus.i_data    = {blk[2*j], blk[2*j+1]};
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_bof   = 1'b0;
    bus.i_eof   = 1'b0;
  endtask

  task automatic collect(input string tag, input int nw, input bit rnd);
    int         cyc;
    logic [5:0] prev_d;
    logic       prev_stall;
    cyc = 0; prev_stall = 1'b0; prev_d = 6'd0; n_got = 0;
    while (n_got < nw && cyc < 3000) begin
      bus.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) check({tag, "_hold"}, 32'(bus.o_data), 32'(prev_d));
      if (bus.o_valid && bus.i_ready) begin
        got_d[n_got] = bus.o_data;
        got_b[n_got] = bus.o_bof;
        got_e[n_got] = bus.o_eof;
        n_got++;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_d     = bus.o_data;
      @(negedge clk);
      cyc++;
    end
    bus.i_ready = 1'b1;
    check({tag, "_count"}, 32'(n_got), 32'(nw));
    check({tag, "_no_extra"}, 32'(bus.o_valid), 32'd0);
  endtask

  task automatic verify(input string tag, input int nw);
    for (int j = 0; j < nw && j < n_got; j++) begin
      check($sformatf("%s_data%0d", tag, j), 32'(got_d[j]), 32'(exp_w[j]));
      check($sformatf("%s_bof%0d", tag, j), 32'(got_b[j]), 32'(j == 0));
      check($sformatf("%s_eof%0d", tag, j), 32'(got_e[j]), 32'(j == nw - 1));
    end
  endtask

  task automatic run_block(input string tag, input int psel, input int n_send,
                           input int k, input int f1, input int f2, input bit rnd);
    build_model(k, f1, f2);
    send_block(psel, n_send);
    collect(tag, k / 2, rnd);
    verify(tag, k / 2);
  endtask

  initial begin
    bus.param_sel = 6'd0;
    bus.i_valid   = 1'b0;
    bus.i_bof     = 1'b0;
    bus.i_eof     = 1'b0;
    bus.i_data    = 2'b00;
    bus.i_ready   = 1'b1;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("rst_o_bof",   32'(bus.o_bof),   32'd0);
    check("rst_o_eof",   32'(bus.o_eof),   32'd0);
    check("rst_o_data",  32'(bus.o_data),  32'd0);
    check("rst_o_ready", 32'(bus.o_ready), 32'd1);
    rst = 1'b0;

    // All-zero K=112 block, plus first-word latency
    fill(1'b0, 0);
    for (int j = 0; j < 56; j++) exp_w[j] = 6'b000000;
    send_block(0, 56);
    check("lat_edge0", 32'(bus.o_valid), 32'd0);
    check("enc_o_ready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    check("lat_edge1", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2", 32'(bus.o_valid), 32'd1);
    collect("zero", 56, 1'b0);
    verify("zero", 56);

    // Impulse at bit 0, K=112
    fill(1'b0, 0);
    blk[0] = 1'b1;
    run_block("imp112", 0, 56, 112, 41, 84, 1'b0);
    check("imp112_w0", 32'(got_d[0]), 32'(6'b111011));
    check("imp112_w1", 32'(got_d[1]), 32'(6'b011011));

    // Impulse at bit 13 = pi(1) for K=40: only z'_b of word 0 sees it
    fill(1'b0, 0);
    blk[13] = 1'b1;
    run_block("imp40", 1, 20, 40, 3, 10, 1'b0);
    check("imp40_w0", 32'(got_d[0]), 32'(6'b000001));

    // Random K=112, then the same data with random downstream stalls
    fill(1'b1, 112);
    run_block("rnd112", 0, 56, 112, 41, 84, 1'b0);
    run_block("rnd112_stall", 0, 56, 112, 41, 84, 1'b1);

    // Remaining table entries and an out-of-range selector
    fill(1'b1, 40);
    run_block("rnd40", 1, 20, 40, 3, 10, 1'b1);
    fill(1'b1, 48);
    run_block("rnd48", 2, 24, 48, 7, 12, 1'b0);
    fill(1'b1, 56);
    run_block("rnd56", 3, 28, 56, 19, 42, 1'b1);
    fill(1'b1, 64);
    run_block("rnd64", 4, 32, 64, 7, 16, 1'b0);
    fill(1'b1, 112);
    run_block("psel9", 9, 56, 112, 41, 84, 1'b0);

    // Early eof on word 10 after a full random block: remaining bits must read as zero
    fill(1'b1, 20);
    run_block("early", 0, 10, 112, 41, 84, 1'b1);

    // Reset during ENC, then a clean block
    fill(1'b1, 112);
    send_block(0, 56);
    repeat (6) @(negedge clk);
    check("pre_rst_o_valid", 32'(bus.o_valid), 32'd1);
    check("pre_rst_o_ready", 32'(bus.o_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_o_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    fill(1'b0, 0);
    blk[0] = 1'b1;
    run_block("post_rst", 0, 56, 112, 41, 84, 1'b0);
    check("post_rst_w0", 32'(got_d[0]), 32'(6'b111011));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
